demux_1to3_stream: RTL and testbench

Registered 1-to-3 stream demultiplexer: the distribution side of the team's 2-bit-select, three-way data mux. One input stream carries a data word plus a 2-bit destination select. The block routes each beat to one of three independently back-pressured output channels, each holding a one-entry output register. Select code 2'b11 has no destination. Such beats are consumed, discarded and reported, never forwarded.

---
 rtl/demux_1to3_stream.sv | 101 ++++++++++
 tb/tb_demux_1to3_stream.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to3_stream.sv
// Registered 1-to-3 stream demultiplexer with one-entry output register per channel.
// Select 2'b11 has no destination: such beats are consumed, dropped and reported.
module demux_1to3_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic [1:0]        s_sel,
    output logic              m0_valid,
    input  logic              m0_ready,
    output logic [DATA_W-1:0] m0_data,
    output logic              m1_valid,
    input  logic              m1_ready,
    output logic [DATA_W-1:0] m1_data,
    output logic              m2_valid,
    input  logic              m2_ready,
    output logic [DATA_W-1:0] m2_data,
    output logic              err_pulse,
    output logic              err_flag,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  drop_count
);

    // Handshake: a beat moves on any cycle where valid && ready are both high at
    // the rising edge; ready never looks at valid, and the sender holds data/sel
    // stable while valid && !ready.
    logic [DATA_W-1:0] r_data [3];
    logic [2:0]        r_valid;
    logic              r_err_pulse;
    logic              r_err_flag;
    logic [CNT_W-1:0]  r_drop_count;

    logic [2:0]        w_m_ready;
    logic              w_accept;
    logic              w_illegal;

    assign w_m_ready = {m2_ready, m1_ready, m0_ready};

    // A channel can take a beat when empty or when its current word drains this edge.
    always_comb begin
        s_ready = 1'b1;
        case (s_sel)
            2'b00:   s_ready = !r_valid[0] || w_m_ready[0];
            2'b01:   s_ready = !r_valid[1] || w_m_ready[1];
            2'b10:   s_ready = !r_valid[2] || w_m_ready[2];
            default: s_ready = 1'b1;
        endcase
    end

    assign w_accept  = s_valid && s_ready;
    assign w_illegal = w_accept && (s_sel == 2'b11);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= '0;
            r_err_pulse  <= 1'b0;
            r_err_flag   <= 1'b0;
            r_drop_count <= '0;
            for (int i = 0; i < 3; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_accept && (s_sel == 2'(i))) begin
                    r_data[i]  <= s_data;
                    r_valid[i] <= 1'b1;
                end else if (r_valid[i] && w_m_ready[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end

            r_err_pulse <= w_illegal;

            // A new illegal beat outranks a same-cycle clear request.
            if (w_illegal) begin
                r_err_flag <= 1'b1;
            end else if (err_clr) begin
                r_err_flag <= 1'b0;
            end

            if (w_illegal && (r_drop_count != {CNT_W{1'b1}})) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    assign m0_valid   = r_valid[0];
    assign m1_valid   = r_valid[1];
    assign m2_valid   = r_valid[2];
    assign m0_data    = r_data[0];
    assign m1_data    = r_data[1];
    assign m2_data    = r_data[2];
    assign err_pulse  = r_err_pulse;
    assign err_flag   = r_err_flag;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_demux_1to3_stream.sv
// Directed bench for demux_1to3_stream: an 8-bit-counter instance and a 2-bit-counter
// instance share the same input stream so saturation can be observed.
module tb_demux_1to3_stream;

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic [7:0] s_data;
    logic [1:0] s_sel;
    logic       m0_ready, m1_ready, m2_ready;
    logic       err_clr;

    logic       s_ready;
    logic       m0_valid, m1_valid, m2_valid;
    logic [7:0] m0_data, m1_data, m2_data;
    logic       err_pulse, err_flag;
    logic [7:0] drop_count;

    logic       sat_s_ready;
    logic       sat_m0_valid, sat_m1_valid, sat_m2_valid;
    logic [7:0] sat_m0_data, sat_m1_data, sat_m2_data;
    logic       sat_err_pulse, sat_err_flag;
    logic [1:0] sat_drop_count;

    int n_cmp;
    int n_err;

    demux_1to3_stream #(.DATA_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sel(s_sel),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_data(m0_data),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_data(m1_data),
        .m2_valid(m2_valid), .m2_ready(m2_ready), .m2_data(m2_data),
        .err_pulse(err_pulse), .err_flag(err_flag), .err_clr(err_clr),
        .drop_count(drop_count)
    );

    demux_1to3_stream #(.DATA_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(sat_s_ready), .s_data(s_data), .s_sel(s_sel),
        .m0_valid(sat_m0_valid), .m0_ready(m0_ready), .m0_data(sat_m0_data),
        .m1_valid(sat_m1_valid), .m1_ready(m1_ready), .m1_data(sat_m1_data),
        .m2_valid(sat_m2_valid), .m2_ready(m2_ready), .m2_data(sat_m2_data),
        .err_pulse(sat_err_pulse), .err_flag(sat_err_flag), .err_clr(err_clr),
        .drop_count(sat_drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d);
        s_valid = v;
        s_sel   = sel;
        s_data  = d;
        #1;
    endtask

    task automatic check_valids(input string tag, input logic [2:0] exp);
        check(tag, {29'd0, m2_valid, m1_valid, m0_valid}, {29'd0, exp});
    endtask

    int sat_exp[5] = '{1, 2, 3, 3, 3};

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        s_valid = 1'b0; s_data = 8'h00; s_sel = 2'b00;
        m0_ready = 1'b1; m1_ready = 1'b1; m2_ready = 1'b1;
        err_clr = 1'b0;

        // Reset state
        step();
        check_valids("rst_valids", 3'b000);
        check("rst_data", {8'd0, m2_data, m1_data, m0_data}, 32'd0);
        check("rst_err", {30'd0, err_pulse, err_flag}, 32'd0);
        check("rst_cnt", drop_count, 32'd0);
        check("rst_sat_cnt", sat_drop_count, 32'd0);
        rst = 1'b0;

        // One beat per channel, all sinks ready
        drive(1'b1, 2'b00, 8'hA1);
        check("t1_rdy0", s_ready, 1);
        step();
        check_valids("t1_v0", 3'b001);
        check("t1_d0", m0_data, 8'hA1);
        drive(1'b1, 2'b01, 8'hB2);
        check("t1_rdy1", s_ready, 1);
        step();
        check_valids("t1_v1", 3'b010);
        check("t1_d1", m1_data, 8'hB2);
        drive(1'b1, 2'b10, 8'hC3);
        check("t1_rdy2", s_ready, 1);
        step();
        check_valids("t1_v2", 3'b100);
        check("t1_d2", m2_data, 8'hC3);
        drive(1'b0, 2'b00, 8'h00);
        step();
        check_valids("t1_idle", 3'b000);

        // Stall ch1, queue a second beat, bypass to ch2, then release
        m1_ready = 1'b0;
        drive(1'b1, 2'b01, 8'h11);
        check("t2_rdy_empty", s_ready, 1);
        step();
        check_valids("t2_v_load", 3'b010);
        check("t2_d_load", m1_data, 8'h11);
        drive(1'b1, 2'b01, 8'h22);
        check("t2_rdy_stall", s_ready, 0);
        step();
        check("t2_d_hold", m1_data, 8'h11);
        check_valids("t2_v_hold", 3'b010);
        drive(1'b1, 2'b10, 8'h33);
        check("t3_rdy_ch2", s_ready, 1);
        step();
        check_valids("t3_v", 3'b110);
        check("t3_d2", m2_data, 8'h33);
        check("t3_d1", m1_data, 8'h11);
        drive(1'b1, 2'b01, 8'h22);
        m1_ready = 1'b1;
        #1;
        check("t2_rdy_release", s_ready, 1);
        step();
        check_valids("t2_v_refill", 3'b010);
        check("t2_d_refill", m1_data, 8'h22);
        drive(1'b0, 2'b00, 8'h00);
        step();
        check_valids("t2_drained", 3'b000);

        // Illegal beats and set-wins-over-clear
        drive(1'b1, 2'b11, 8'hFF);
        check("t4_rdy", s_ready, 1);
        step();
        check_valids("t4_no_valid", 3'b000);
        check("t4_pulse", err_pulse, 1);
        check("t4_flag", err_flag, 1);
        check("t4_cnt", drop_count, 1);
        err_clr = 1'b1;
        drive(1'b1, 2'b11, 8'hFE);
        step();
        check("t4_pulse2", err_pulse, 1);
        check("t4_flag_setwins", err_flag, 1);
        check("t4_cnt2", drop_count, 2);
        drive(1'b0, 2'b00, 8'h00);
        step();
        check("t4_pulse_end", err_pulse, 0);
        check("t4_flag_clr", err_flag, 0);
        check("t4_cnt_keep", drop_count, 2);
        err_clr = 1'b0;

        // Saturation of the 2-bit counter from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_cnt_reset", sat_drop_count, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b11, 8'(i));
            step();
            check($sformatf("t5_sat_cnt%0d", i), sat_drop_count, sat_exp[i]);
            check($sformatf("t5_cnt%0d", i), drop_count, i + 1);
        end
        drive(1'b0, 2'b00, 8'h00);
        step();
        check("t5_sat_hold", sat_drop_count, 3);

        // Reset while ch0 is full and an illegal beat is offered
        m0_ready = 1'b0;
        drive(1'b1, 2'b00, 8'h5A);
        step();
        check_valids("t6_full", 3'b001);
        check("t6_d0", m0_data, 8'h5A);
        rst = 1'b1;
        drive(1'b1, 2'b11, 8'h77);
        step();
        rst = 1'b0;
        drive(1'b0, 2'b00, 8'h00);
        check_valids("t6_valids", 3'b000);
        check("t6_data", {8'd0, m2_data, m1_data, m0_data}, 32'd0);
        check("t6_err", {30'd0, err_pulse, err_flag}, 32'd0);
        check("t6_cnt", drop_count, 0);
        check("t6_sat_cnt", sat_drop_count, 0);
        check("t6_rdy", s_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
